// File: rtl/reg_file_param.sv
// Parametrised register file: two forwarding read ports, one write port,
// a dedicated RA link port and hardware SP push/pop with sticky bound fault.
module reg_file_param #(
    parameter int                DATA_W = 10,
    parameter int                ADDR_W = 3,
    parameter int                T0_IDX = 4,
    parameter int                RA_IDX = 6,
    parameter int                SP_IDX = 7,
    parameter logic [DATA_W-1:0] SP_TOP = 10'h3FF
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write_en,
    input  logic              ldst_en,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    input  logic [1:0]        sp_op,
    output logic [DATA_W-1:0] reg1_out,
    output logic [DATA_W-1:0] reg2_out,
    output logic [DATA_W-1:0] t0out,
    output logic [DATA_W-1:0] ra_out,
    output logic [DATA_W-1:0] sp_out,
    output logic              sp_fault
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] T0_A = T0_IDX[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] RA_A = RA_IDX[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] SP_A = SP_IDX[ADDR_W-1:0];
    localparam logic              LINK_HITS_SP = (RA_IDX == SP_IDX);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              fault_q;
    logic              push;
    logic              pop;
    logic              sp_dropped;

    assign push = (sp_op == 2'b01);
    assign pop  = (sp_op == 2'b10);
    // A general or link write to SP in the same cycle wins; the stack op is discarded silently.
    assign sp_dropped = (reg_write_en && (write_reg == SP_A)) || (link_en && LINK_HITS_SP);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            regs       <= '{default: '0};
            regs[SP_A] <= SP_TOP;
            fault_q    <= 1'b0;
        end else begin
            if (!sp_dropped && push) begin
                if (regs[SP_A] == '0) fault_q <= 1'b1;
                else                  regs[SP_A] <= regs[SP_A] - 1'b1;
            end
            if (!sp_dropped && pop) begin
                if (regs[SP_A] == SP_TOP) fault_q <= 1'b1;
                else                      regs[SP_A] <= regs[SP_A] + 1'b1;
            end
            // Later assignments take precedence: general write > link > stack op.
            if (link_en)      regs[RA_A]      <= link_data;
            if (reg_write_en) regs[write_reg] <= write_data;
        end
    end

    always_comb begin
        reg1_out = regs[read_reg1];
        reg2_out = regs[read_reg2];
        if (reg_write_en && !reset && (read_reg1 == write_reg)) reg1_out = write_data;
        if (reg_write_en && !reset && (read_reg2 == write_reg)) reg2_out = write_data;
        if (ldst_en) reg2_out = DATA_W'(read_reg2);
    end

    assign t0out    = regs[T0_A];
    assign ra_out   = regs[RA_A];
    assign sp_out   = regs[SP_A];
    assign sp_fault = fault_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed vector table plus randomized cycles
// checked against an array-based model of the register file.
module tb_reg_file_param;
    localparam int DW = 10;
    localparam int AW = 3;
    localparam logic [DW-1:0] TOP = 10'h3FF;

    typedef struct {
        logic          rst;
        logic          we;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          ldst;
        logic          link;
        logic [DW-1:0] ld;
        logic [1:0]    spop;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic [DW-1:0] et0;
        logic [DW-1:0] era;
        logic [DW-1:0] esp;
        logic          ef;
    } vec_t;

    logic          clk_in = 1'b0;
    logic          reset;
    logic [AW-1:0] read_reg1, read_reg2, write_reg;
    logic [DW-1:0] write_data, link_data;
    logic          reg_write_en, ldst_en, link_en;
    logic [1:0]    sp_op;
    logic [DW-1:0] reg1_out, reg2_out, t0out, ra_out, sp_out;
    logic          sp_fault;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    logic [DW-1:0] m [8];
    logic          mf;

    reg_file_param dut (
        .clk_in(clk_in), .reset(reset),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data),
        .reg_write_en(reg_write_en), .ldst_en(ldst_en),
        .link_en(link_en), .link_data(link_data), .sp_op(sp_op),
        .reg1_out(reg1_out), .reg2_out(reg2_out),
        .t0out(t0out), .ra_out(ra_out), .sp_out(sp_out), .sp_fault(sp_fault)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%03h expected 0x%03h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst;  reg_write_en = v.we; write_reg = v.wr; write_data = v.wd;
        read_reg1 = v.r1; read_reg2 = v.r2; ldst_en = v.ldst;
        link_en = v.link; link_data = v.ld; sp_op = v.spop;
    endtask

    task automatic add(input logic rst, input logic we, input int wr, input int wd,
                       input int r1, input int r2, input logic ldst, input logic link,
                       input int ld, input int spop, input int e1, input int e2,
                       input int et0, input int era, input int esp, input logic ef);
        vec_t v;
        v.rst = rst; v.we = we; v.wr = AW'(wr); v.wd = DW'(wd);
        v.r1 = AW'(r1); v.r2 = AW'(r2); v.ldst = ldst; v.link = link;
        v.ld = DW'(ld); v.spop = 2'(spop);
        v.e1 = DW'(e1); v.e2 = DW'(e2); v.et0 = DW'(et0); v.era = DW'(era);
        v.esp = DW'(esp); v.ef = ef;
        vecs.push_back(v);
    endtask

    // Model: reads with forwarding, then the register update for one edge.
    function automatic logic [DW-1:0] model_read(input vec_t v, input logic [AW-1:0] a, input logic port2);
        if (port2 && v.ldst) return DW'(a);
        if (v.we && !v.rst && a == v.wr) return v.wd;
        return m[a];
    endfunction

    task automatic model_step(input vec_t v);
        logic [DW-1:0] nx [8];
        if (v.rst) begin
            foreach (m[i]) m[i] = '0;
            m[7] = TOP;
            mf = 1'b0;
            return;
        end
        nx = m;
        if (!(v.we && v.wr == 3'd7)) begin
            if (v.spop == 2'd1) begin
                if (m[7] == 0) mf = 1'b1; else nx[7] = m[7] - 1;
            end else if (v.spop == 2'd2) begin
                if (m[7] == TOP) mf = 1'b1; else nx[7] = m[7] + 1;
            end
        end
        if (v.link) nx[6] = v.ld;
        if (v.we) nx[v.wr] = v.wd;
        m = nx;
    endtask

    initial begin
        vec_t v;
        // Directed table; expectations written from the behavioural rules.
        for (int i = 0; i < 8; i++)
            add(0,0,0,0, i,i,0,0,0,0, (i==7)?'h3FF:0, (i==7)?'h3FF:0, 0,0,'h3FF,0);
        add(0,1,4,'h155, 4,5,1,0,0,0, 'h155,'h005, 'h155,0,'h3FF,0);
        add(0,0,0,0, 4,7,0,0,0,2, 'h155,'h3FF, 'h155,0,'h3FF,1);
        add(0,0,0,0, 7,4,0,0,0,1, 'h3FF,'h155, 'h155,0,'h3FE,1);
        add(0,0,0,0, 7,4,0,0,0,1, 'h3FE,'h155, 'h155,0,'h3FD,1);
        add(0,0,0,0, 7,4,0,0,0,1, 'h3FD,'h155, 'h155,0,'h3FC,1);
        add(1,1,1,'h3C3, 1,4,0,0,0,1, 0,'h155, 0,0,'h3FF,0);
        add(0,0,0,0, 1,7,0,0,0,0, 0,'h3FF, 0,0,'h3FF,0);
        add(0,0,0,0, 7,1,0,0,0,3, 'h3FF,0, 0,0,'h3FF,0);
        add(0,1,7,'h200, 7,7,0,0,0,2, 'h200,'h200, 0,0,'h200,0);
        add(0,1,7,'h001, 7,0,0,0,0,0, 'h001,0, 0,0,'h001,0);
        add(0,0,0,0, 7,0,0,0,0,1, 'h001,0, 0,0,'h000,0);
        add(0,0,0,0, 7,0,0,0,0,1, 'h000,0, 0,0,'h000,1);
        add(0,1,6,'h0AA, 6,6,0,1,'h123,0, 'h0AA,'h0AA, 0,'h0AA,'h000,1);
        add(0,1,0,'h2B4, 0,6,0,1,'h123,0, 'h2B4,'h0AA, 0,'h123,'h000,1);
        add(0,0,0,0, 0,6,0,0,0,0, 'h2B4,'h123, 0,'h123,'h000,1);
        add(0,1,7,'h3FF, 7,7,1,0,0,1, 'h3FF,'h007, 0,'h123,'h3FF,1);
        add(0,0,0,0, 6,3,1,0,0,2, 'h123,'h003, 0,'h123,'h3FF,1);

        v = '{default: '0};
        v.rst = 1'b1;
        drive(v);
        @(posedge clk_in); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #3;
            check("reg1_out", i, reg1_out, vecs[i].e1);
            check("reg2_out", i, reg2_out, vecs[i].e2);
            @(posedge clk_in); #1;
            check("t0out", i, t0out, vecs[i].et0);
            check("ra_out", i, ra_out, vecs[i].era);
            check("sp_out", i, sp_out, vecs[i].esp);
            check("sp_fault", i, DW'(sp_fault), DW'(vecs[i].ef));
        end

        // Randomized phase against the model, starting from a reset.
        v = '{default: '0};
        v.rst = 1'b1;
        drive(v);
        model_step(v);
        @(posedge clk_in); #1;
        for (int i = 0; i < 400; i++) begin
            v.rst  = ($urandom_range(0, 39) == 0);
            v.we   = ($urandom_range(0, 1) == 1);
            v.wr   = AW'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       v.wd = 10'h000;
                1:       v.wd = 10'h001;
                2:       v.wd = 10'h3FE;
                default: v.wd = DW'($urandom);
            endcase
            v.r1   = AW'($urandom_range(0, 7));
            v.r2   = ($urandom_range(0, 2) == 0) ? v.wr : AW'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) v.r1 = v.wr;
            v.ldst = ($urandom_range(0, 3) == 0);
            v.link = ($urandom_range(0, 3) == 0);
            v.ld   = DW'($urandom);
            v.spop = 2'($urandom_range(0, 3));
            drive(v);
            #3;
            check("rand reg1_out", i, reg1_out, model_read(v, v.r1, 1'b0));
            check("rand reg2_out", i, reg2_out, model_read(v, v.r2, 1'b1));
            model_step(v);
            @(posedge clk_in); #1;
            check("rand t0out", i, t0out, m[4]);
            check("rand ra_out", i, ra_out, m[6]);
            check("rand sp_out", i, sp_out, m[7]);
            check("rand sp_fault", i, DW'(sp_fault), DW'(mf));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
